tcp_tx_arbiter: RTL and testbench

TCP_TX_ARBITER -- requirements
Module: tcp_tx_arbiter

---
 rtl/tcp_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_tcp_tx_arbiter.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter merging NUM_SRC byte-stream sources into the SiTCP TX byte port.
// Each granted frame goes out as one tag/index header byte followed by the source bytes.
//
// state | meaning
// IDLE  | no owner; picks next valid source at or after rr_ptr
// HDR   | owner granted; header byte waits for TX space
// DATA  | source bytes forwarded with one cycle of latency
// DRAIN | link lost mid-frame; bytes accepted and discarded until LAST
module tcp_tx_arbiter #(
  parameter int         NUM_SRC = 4,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   TCP_OPEN,
  input  logic                   TCP_RST,
  input  logic                   TCP_TX_FULL,
  output logic                   TCP_TX_WR,
  output logic [7:0]             TCP_TX_DATA,
  input  logic [NUM_SRC-1:0]     SRC_VALID,
  input  logic [8*NUM_SRC-1:0]   SRC_DATA,
  input  logic [NUM_SRC-1:0]     SRC_LAST,
  output logic [NUM_SRC-1:0]     SRC_READY,
  output logic [NUM_SRC-1:0]     GRANT,
  output logic                   BUSY,
  output logic [15:0]            DROP_CNT
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [3:0]         gidx, gidx_nxt;
  logic [3:0]         rr_ptr, rr_nxt;
  logic [NUM_SRC-1:0] grant_nxt;
  logic               wr_nxt;
  logic [7:0]         data_nxt;
  logic [15:0]        drop_nxt;

  logic               link_ok;
  logic               hi_found, lo_found;
  logic [3:0]         hi_sel, lo_sel, pick;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;
  logic [3:0]         rr_adv;

  assign link_ok = TCP_OPEN & ~TCP_RST;
  assign BUSY    = (state != IDLE);
  assign rr_adv  = (gidx == 4'(NUM_SRC - 1)) ? 4'd0 : gidx + 4'd1;

  // Lowest valid index at/above rr_ptr wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = 4'd0;
    lo_sel   = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (SRC_VALID[i]) begin
        lo_found = 1'b1;
        lo_sel   = 4'(i);
        if (4'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_sel   = 4'(i);
        end
      end
    end
    pick = hi_found ? hi_sel : lo_sel;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (GRANT[i]) begin
        sel_valid = SRC_VALID[i];
        sel_last  = SRC_LAST[i];
        sel_data  = SRC_DATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = GRANT;
    gidx_nxt  = gidx;
    rr_nxt    = rr_ptr;
    wr_nxt    = 1'b0;
    data_nxt  = TCP_TX_DATA;
    drop_nxt  = DROP_CNT;
    SRC_READY = '0;
    case (state)
      IDLE: begin
        if (link_ok && lo_found) begin
          state_nxt = HDR;
          gidx_nxt  = pick;
          for (int i = 0; i < NUM_SRC; i++) grant_nxt[i] = (4'(i) == pick);
        end
      end
      HDR: begin
        if (!link_ok) begin
          state_nxt = DRAIN;
        end else if (!TCP_TX_FULL) begin
          wr_nxt    = 1'b1;
          data_nxt  = {HDR_TAG, gidx};
          state_nxt = DATA;
        end
      end
      DATA: begin
        SRC_READY = GRANT & {NUM_SRC{link_ok & ~TCP_TX_FULL}};
        if (!link_ok) begin
          state_nxt = DRAIN;
        end else if (!TCP_TX_FULL && sel_valid) begin
          wr_nxt   = 1'b1;
          data_nxt = sel_data;
          if (sel_last) begin
            state_nxt = IDLE;
            rr_nxt    = rr_adv;
            grant_nxt = '0;
          end
        end
      end
      DRAIN: begin
        // Link is gone, so backpressure no longer matters; swallow the rest of the frame.
        SRC_READY = GRANT;
        if (sel_valid && sel_last) begin
          drop_nxt  = (DROP_CNT == 16'hFFFF) ? DROP_CNT : DROP_CNT + 16'd1;
          rr_nxt    = rr_adv;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      GRANT       <= '0;
      gidx        <= 4'd0;
      rr_ptr      <= 4'd0;
      TCP_TX_WR   <= 1'b0;
      TCP_TX_DATA <= 8'h00;
      DROP_CNT    <= 16'h0000;
    end else begin
      state       <= state_nxt;
      GRANT       <= grant_nxt;
      gidx        <= gidx_nxt;
      rr_ptr      <= rr_nxt;
      TCP_TX_WR   <= wr_nxt;
      TCP_TX_DATA <= data_nxt;
      DROP_CNT    <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Self-checking bench for tcp_tx_arbiter: queue-based sources, write/transfer recorder,
// and a round-robin frame-order model for the randomized backpressure run.
module tb_tcp_tx_arbiter;
  localparam int NS = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            TCP_OPEN = 1'b0;
  logic            TCP_RST = 1'b0;
  logic            TCP_TX_FULL = 1'b0;
  logic            TCP_TX_WR;
  logic [7:0]      TCP_TX_DATA;
  logic [NS-1:0]   SRC_VALID = '0;
  logic [8*NS-1:0] SRC_DATA = '0;
  logic [NS-1:0]   SRC_LAST = '0;
  logic [NS-1:0]   SRC_READY;
  logic [NS-1:0]   GRANT;
  logic            BUSY;
  logic [15:0]     DROP_CNT;

  tcp_tx_arbiter #(.NUM_SRC(NS), .HDR_TAG(4'hA)) dut (
    .CLK(CLK), .RST(RST), .TCP_OPEN(TCP_OPEN), .TCP_RST(TCP_RST),
    .TCP_TX_FULL(TCP_TX_FULL), .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA),
    .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_LAST(SRC_LAST),
    .SRC_READY(SRC_READY), .GRANT(GRANT), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  always #4 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0]    src_q [NS][$];
  logic [NS-1:0] xfer_s = '0;
  int            cyc = 0;
  int            xfer_cnt = 0;
  int            bad_xfer = 0;
  int            grant_chg = 0;
  logic [NS-1:0] grant_or = '0;
  logic [7:0]    wr_q [$];
  int            wr_cyc_q [$];
  bit            xfer_at [int];
  logic [NS-1:0] last_grant = '0;
  logic          last_busy = 1'b0;
  int            full_mode = 0;

  function void drive_srcs();
    logic [8:0] e;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        e = src_q[i][0];
        SRC_VALID[i]       = 1'b1;
        SRC_DATA[8*i +: 8] = e[7:0];
        SRC_LAST[i]        = e[8];
      end else begin
        SRC_VALID[i]       = 1'b0;
        SRC_DATA[8*i +: 8] = 8'h00;
        SRC_LAST[i]        = 1'b0;
      end
    end
  endfunction

  function void push_byte(int s, logic [7:0] b, bit last);
    src_q[s].push_back({last, b});
  endfunction

  function void flush_srcs();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    drive_srcs();
  endfunction

  function bit srcs_empty();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  function void clear_logs();
    wr_q.delete();
    wr_cyc_q.delete();
    xfer_at.delete();
    xfer_cnt  = 0;
    bad_xfer  = 0;
    grant_chg = 0;
    grant_or  = '0;
  endfunction

  // Recorder: writes seen after each edge, and handshakes about to happen on the next edge.
  initial forever begin
    @(negedge CLK);
    cyc++;
    xfer_s = SRC_VALID & SRC_READY;
    if (TCP_TX_WR === 1'b1) begin
      wr_q.push_back(TCP_TX_DATA);
      wr_cyc_q.push_back(cyc);
    end
    if (xfer_s != '0) begin
      xfer_at[cyc] = 1'b1;
      xfer_cnt++;
      if (xfer_s != GRANT || $countones(xfer_s) != 1) bad_xfer++;
    end
    if (BUSY && last_busy && GRANT != last_grant) grant_chg++;
    if (BUSY) grant_or = grant_or | GRANT;
    last_busy  = BUSY;
    last_grant = GRANT;
  end

  // Source side: retire accepted bytes, present the next ones.
  initial forever begin
    @(posedge CLK);
    #1;
    for (int i = 0; i < NS; i++)
      if (xfer_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive_srcs();
  end

  initial begin
    int fc;
    fc = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (full_mode == 1) begin
        fc++;
        if (fc >= 3) begin
          TCP_TX_FULL = ~TCP_TX_FULL;
          fc = 0;
        end
      end else if (full_mode == 2) begin
        TCP_TX_FULL = 1'($urandom_range(0, 1));
      end else begin
        fc = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int budget, output bit to);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
      done = (BUSY === 1'b0) && srcs_empty();
    end
    to = !done;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    TCP_OPEN = 1'b1;
    TCP_RST = 1'b0;
    full_mode = 0;
    TCP_TX_FULL = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    flush_srcs();
    @(negedge CLK);
    #1;
    RST = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    TCP_OPEN = 1'b1;
    push_byte(0, 8'h55, 1'b1);
    drive_srcs();
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (TCP_TX_WR !== 1'b0) begin n_err++; $display("FAIL reset_tx_wr: got %b want 0", TCP_TX_WR); end
    n_cmp++; if (TCP_TX_DATA !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", TCP_TX_DATA); end
    n_cmp++; if (SRC_READY !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", SRC_READY); end
    n_cmp++; if (GRANT !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", GRANT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (DROP_CNT !== 16'h0000) begin n_err++; $display("FAIL reset_drop_cnt: got %h want 0000", DROP_CNT); end
    do_reset();
  endtask

  task automatic test_single_frame();
    logic [7:0] exp [4];
    bit to;
    exp = '{8'hA2, 8'h11, 8'h22, 8'h33};
    do_reset();
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h22, 1'b0);
    push_byte(2, 8'h33, 1'b1);
    drive_srcs();
    wait_idle(200, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL single_timeout: frame not finished, want finished"); end
    n_cmp++; if (wr_q.size() != 4) begin n_err++; $display("FAIL single_count: got %0d writes want 4", wr_q.size()); end
    for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
      n_cmp++;
      if (wr_q[k] !== exp[k]) begin n_err++; $display("FAIL single_byte%0d: got %h want %h", k, wr_q[k], exp[k]); end
    end
    if (wr_cyc_q.size() == 4) begin
      n_cmp++;
      if (wr_cyc_q[3] - wr_cyc_q[0] != 3) begin n_err++; $display("FAIL single_consecutive: span %0d want 3", wr_cyc_q[3] - wr_cyc_q[0]); end
    end
    n_cmp++; if (grant_or !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", grant_or); end
    n_cmp++; if (GRANT !== 4'b0000 || BUSY !== 1'b0) begin n_err++; $display("FAIL single_idle: grant %b busy %b want 0000 0", GRANT, BUSY); end
  endtask

  task automatic test_single_byte();
    bit to;
    clear_logs();
    push_byte(1, 8'h5A, 1'b1);
    drive_srcs();
    wait_idle(100, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL onebyte_timeout: not finished, want finished"); end
    n_cmp++; if (wr_q.size() != 2) begin n_err++; $display("FAIL onebyte_count: got %0d want 2", wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== 8'hA1 || wr_q[1] !== 8'h5A) begin n_err++; $display("FAIL onebyte_data: got %h %h want a1 5a", wr_q[0], wr_q[1]); end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp [12];
    bit to;
    exp = '{8'hA0, 8'h01, 8'h02, 8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04, 8'hA3, 8'h33, 8'h34};
    do_reset();
    push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1);
    push_byte(0, 8'h03, 1'b0); push_byte(0, 8'h04, 1'b1);
    push_byte(3, 8'h31, 1'b0); push_byte(3, 8'h32, 1'b1);
    push_byte(3, 8'h33, 1'b0); push_byte(3, 8'h34, 1'b1);
    drive_srcs();
    wait_idle(300, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL rr_timeout: not finished, want finished"); end
    n_cmp++; if (wr_q.size() != 12) begin n_err++; $display("FAIL rr_count: got %0d want 12", wr_q.size()); end
    for (int k = 0; k < 12 && k < wr_q.size(); k++) begin
      n_cmp++;
      if (wr_q[k] !== exp[k]) begin n_err++; $display("FAIL rr_byte%0d: got %h want %h", k, wr_q[k], exp[k]); end
    end
    n_cmp++; if (bad_xfer != 0 || grant_chg != 0) begin n_err++; $display("FAIL rr_interleave: bad %0d chg %0d want 0 0", bad_xfer, grant_chg); end
  endtask

  task automatic test_backpressure();
    bit to;
    int lat_bad;
    do_reset();
    for (int k = 0; k < 16; k++) push_byte(1, 8'(8'h40 + k), k == 15);
    full_mode = 1;
    drive_srcs();
    wait_idle(400, to);
    full_mode = 0;
    TCP_TX_FULL = 1'b0;
    n_cmp++; if (to) begin n_err++; $display("FAIL bp_timeout: not finished, want finished"); end
    n_cmp++; if (wr_q.size() != 17) begin n_err++; $display("FAIL bp_count: got %0d want 17", wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== 8'hA1) begin n_err++; $display("FAIL bp_header: got %h want a1", wr_q[0]); end
      for (int k = 1; k < 17; k++) begin
        n_cmp++;
        if (wr_q[k] !== 8'(8'h40 + k - 1)) begin n_err++; $display("FAIL bp_byte%0d: got %h want %h", k, wr_q[k], 8'(8'h40 + k - 1)); end
      end
      lat_bad = 0;
      for (int k = 1; k < 17; k++) if (!xfer_at.exists(wr_cyc_q[k] - 1)) lat_bad++;
      n_cmp++; if (lat_bad != 0) begin n_err++; $display("FAIL bp_latency: %0d writes without prior transfer, want 0", lat_bad); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    bit         hdr_q [$];
    int         rem [NS];
    int         pos [NS];
    int         total, rr, idx, lat_bad, len;
    bit         found, to;
    logic [8:0] e;
    do_reset();
    total = 0;
    for (int s = 0; s < NS; s++) begin
      rem[s] = 3;
      pos[s] = 0;
      total += 3;
      for (int f = 0; f < 3; f++) begin
        len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) push_byte(s, 8'($urandom), b == len - 1);
      end
    end
    rr = 0;
    while (total > 0) begin
      found = 1'b0;
      idx = 0;
      for (int k = 0; k < NS; k++)
        if (!found && rem[(rr + k) % NS] > 0) begin found = 1'b1; idx = (rr + k) % NS; end
      exp_q.push_back({4'hA, 4'(idx)});
      hdr_q.push_back(1'b1);
      do begin
        e = src_q[idx][pos[idx]];
        pos[idx]++;
        exp_q.push_back(e[7:0]);
        hdr_q.push_back(1'b0);
      end while (!e[8]);
      rem[idx]--;
      total--;
      rr = (idx + 1) % NS;
    end
    full_mode = 2;
    drive_srcs();
    wait_idle(3000, to);
    full_mode = 0;
    TCP_TX_FULL = 1'b0;
    n_cmp++; if (to) begin n_err++; $display("FAIL rand_timeout: not finished, want finished"); end
    n_cmp++; if (wr_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
    lat_bad = 0;
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      n_cmp++;
      if (wr_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rand_byte%0d: got %h want %h", k, wr_q[k], exp_q[k]); end
      if (!hdr_q[k] && !xfer_at.exists(wr_cyc_q[k] - 1)) lat_bad++;
    end
    n_cmp++; if (lat_bad != 0) begin n_err++; $display("FAIL rand_latency: %0d writes without prior transfer, want 0", lat_bad); end
    n_cmp++; if (bad_xfer != 0 || grant_chg != 0) begin n_err++; $display("FAIL rand_interleave: bad %0d chg %0d want 0 0", bad_xfer, grant_chg); end
  endtask

  task automatic test_closed();
    int viol;
    bit to;
    do_reset();
    TCP_OPEN = 1'b0;
    push_byte(0, 8'hC0, 1'b0); push_byte(0, 8'hC1, 1'b1);
    push_byte(2, 8'hC2, 1'b0); push_byte(2, 8'hC3, 1'b1);
    drive_srcs();
    viol = 0;
    repeat (100) begin
      @(negedge CLK);
      if (GRANT != '0 || TCP_TX_WR || BUSY || SRC_READY != '0) viol++;
    end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL closed_idle: %0d active cycles want 0", viol); end
    TCP_OPEN = 1'b1;
    TCP_RST = 1'b1;
    viol = 0;
    repeat (30) begin
      @(negedge CLK);
      if (GRANT != '0 || TCP_TX_WR || BUSY || SRC_READY != '0) viol++;
    end
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL tcprst_idle: %0d active cycles want 0", viol); end
    TCP_RST = 1'b0;
    wait_idle(200, to);
    n_cmp++; if (to || wr_q.size() != 6) begin n_err++; $display("FAIL closed_resume: timeout %b writes %0d want 0 6", to, wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== 8'hA0 || wr_q[3] !== 8'hA2) begin n_err++; $display("FAIL closed_headers: got %h %h want a0 a2", wr_q[0], wr_q[3]); end
    end
  endtask

  task automatic test_drop();
    int n;
    bit to;
    clear_logs();
    for (int k = 0; k < 6; k++) push_byte(0, 8'(8'h60 + k), k == 5);
    drive_srcs();
    n = 0;
    while (xfer_cnt < 2 && n < 100) begin @(negedge CLK); #1; n++; end
    n_cmp++; if (xfer_cnt < 2) begin n_err++; $display("FAIL drop_start: got %0d transfers want 2", xfer_cnt); end
    @(posedge CLK);
    #2;
    TCP_OPEN = 1'b0;
    wait_idle(200, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL drop_timeout: drain not finished, want finished"); end
    n_cmp++; if (wr_q.size() != 3) begin n_err++; $display("FAIL drop_count: got %0d writes want 3", wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== 8'hA0 || wr_q[1] !== 8'h60 || wr_q[2] !== 8'h61) begin n_err++; $display("FAIL drop_data: got %h %h %h want a0 60 61", wr_q[0], wr_q[1], wr_q[2]); end
    end
    n_cmp++; if (xfer_cnt != 6) begin n_err++; $display("FAIL drop_drained: got %0d transfers want 6", xfer_cnt); end
    n_cmp++; if (DROP_CNT !== 16'd1) begin n_err++; $display("FAIL drop_cnt: got %0d want 1", DROP_CNT); end
    n_cmp++; if (GRANT !== 4'b0000) begin n_err++; $display("FAIL drop_grant: got %b want 0000", GRANT); end
    TCP_RST = 1'b1;
    repeat (3) @(negedge CLK);
    TCP_RST = 1'b0;
    TCP_OPEN = 1'b1;
    #1;
    n_cmp++; if (DROP_CNT !== 16'd1) begin n_err++; $display("FAIL tcprst_drop_cnt: got %0d want 1", DROP_CNT); end
    clear_logs();
    push_byte(0, 8'h70, 1'b1);
    push_byte(1, 8'h71, 1'b1);
    drive_srcs();
    wait_idle(100, to);
    n_cmp++; if (to || wr_q.size() != 4) begin n_err++; $display("FAIL tcprst_rr_count: timeout %b writes %0d want 0 4", to, wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== 8'hA1 || wr_q[2] !== 8'hA0) begin n_err++; $display("FAIL tcprst_rr_order: got %h %h want a1 a0", wr_q[0], wr_q[2]); end
    end
  endtask

  task automatic test_rst_mid();
    int n;
    bit to;
    clear_logs();
    for (int k = 0; k < 8; k++) push_byte(2, 8'(8'h80 + k), k == 7);
    drive_srcs();
    n = 0;
    while (wr_q.size() < 2 && n < 100) begin @(negedge CLK); #1; n++; end
    n_cmp++; if (BUSY !== 1'b1 || DROP_CNT !== 16'd1) begin n_err++; $display("FAIL rstmid_pre: busy %b drop %0d want 1 1", BUSY, DROP_CNT); end
    #1;
    RST = 1'b1;
    #1;
    n_cmp++; if (TCP_TX_WR !== 1'b0 || TCP_TX_DATA !== 8'h00) begin n_err++; $display("FAIL rstmid_tx: wr %b data %h want 0 00", TCP_TX_WR, TCP_TX_DATA); end
    n_cmp++; if (SRC_READY !== 4'b0000 || GRANT !== 4'b0000) begin n_err++; $display("FAIL rstmid_grant: ready %b grant %b want 0000 0000", SRC_READY, GRANT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
    n_cmp++; if (DROP_CNT !== 16'h0000) begin n_err++; $display("FAIL rstmid_drop_cnt: got %0d want 0", DROP_CNT); end
    repeat (2) @(posedge CLK);
    #2;
    flush_srcs();
    push_byte(3, 8'h31, 1'b0); push_byte(3, 8'h32, 1'b1);
    push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1);
    drive_srcs();
    @(negedge CLK);
    #1;
    RST = 1'b0;
    clear_logs();
    wait_idle(200, to);
    n_cmp++; if (to || wr_q.size() != 6) begin n_err++; $display("FAIL rstmid_resume: timeout %b writes %0d want 0 6", to, wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== 8'hA0 || wr_q[3] !== 8'hA3) begin n_err++; $display("FAIL rstmid_order: got %h %h want a0 a3", wr_q[0], wr_q[3]); end
    end
    n_cmp++; if (DROP_CNT !== 16'h0000) begin n_err++; $display("FAIL rstmid_drop_after: got %0d want 0", DROP_CNT); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_single_byte();
    test_round_robin();
    test_backpressure();
    test_random();
    test_closed();
    test_drop();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
